// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end.
// FSM state encoding, PC step and the FIFO entry layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  localparam int PC_INC  = 4;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries for the fetch buffer.
// Flush has priority over push and pop; pointers wrap modulo DEPTH.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign head    = mem[rd];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop)  rd <= rd + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: sequential PC, req/ack memory port, prefetch FIFO.
// Optional FETCH_BUFFER_PERF_EN adds saturating stall_cnt and flush_cnt outputs.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_BUFFER_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rpc;
  logic [EW-1:0]     head;
  logic [CW-1:0]     count;
  logic [CW-1:0]     post;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign rpc  = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign push = (state == WAIT) & mem_ack & ~redirect;
  assign pop  = inst_valid & inst_ready;
  assign post = count + CW'(1) - CW'(pop);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({fetch_pc, mem_rdata}),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign mem_req    = (state != IDLE);
  assign mem_addr   = addr_q;
  assign inst_valid = ~empty;
  assign inst_pc    = empty ? '0 : head[EW-1:DATA_W];
  assign inst_out   = empty ? '0 : head[DATA_W-1:0];

  // Next state and next fetch PC.
  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    unique case (1'b1)
      state == IDLE: begin
        if (redirect)   pc_n    = rpc;
        else if (!full) state_n = WAIT;
      end
      state == WAIT: begin
        if (redirect) begin
          pc_n    = rpc;
          state_n = mem_ack ? IDLE : DROP;
        end else if (mem_ack) begin
          pc_n    = fetch_pc + ADDR_W'(PC_INC);
          state_n = (post < CW'(DEPTH)) ? WAIT : IDLE;
        end
      end
      state == DROP: begin
        if (redirect) pc_n    = rpc;
        if (mem_ack)  state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, PC and request-address registers; address latched on issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= pc_n;
      if (state_n == WAIT) addr_q <= pc_n;
    end
  end

`ifdef FETCH_BUFFER_PERF_EN
  // Saturating stall and redirect counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (inst_ready & ~inst_valid & ~&stall_cnt)
        stall_cnt <= stall_cnt + 32'd1;
      if (redirect & ~&flush_cnt)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: fetch order, backpressure, redirects,
// PC wrap and asynchronous reset, with hand-computed expectations.
module tb_fetch_buffer;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int vectors;
  int miscompares;

  fetch_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic [31:0] pc,
                      input logic [31:0] data);
    chk({tag, "_valid"}, inst_valid, 1'b1);
    chk({tag, "_pc"}, inst_pc, pc);
    chk({tag, "_out"}, inst_out, data);
  endtask

  task automatic serve(input int lat, input logic [31:0] data,
                       input logic [31:0] addr);
    int n;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", mem_req, 1'b1);
    chk("req_addr", mem_addr, addr);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("req_hold", mem_req, 1'b1);
      chk("addr_hold", mem_addr, addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    mem_ack  = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    tick();
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_out", inst_out, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);

    // 1: two-cycle memory, core always ready
    inst_ready = 1'b1;
    rst = 1'b0;
    serve(2, 32'hA000_0000, 32'h0);
    head("t1_0", 32'h0, 32'hA000_0000);
    serve(2, 32'hA000_0004, 32'h4);
    head("t1_4", 32'h4, 32'hA000_0004);
    serve(2, 32'hA000_0008, 32'h8);
    head("t1_8", 32'h8, 32'hA000_0008);

    // 2: core stalled, zero-wait memory fills the FIFO
    inst_ready = 1'b0;
    do_reset();
    serve(0, 32'hB000_0000, 32'h0);
    serve(0, 32'hB000_0004, 32'h4);
    serve(0, 32'hB000_0008, 32'h8);
    serve(0, 32'hB000_000C, 32'hC);
    chk("t2_full_req", mem_req, 1'b0);
    head("t2_h0", 32'h0, 32'hB000_0000);
    tick();
    chk("t2_full_req2", mem_req, 1'b0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    head("t2_h4", 32'h4, 32'hB000_0004);
    chk("t2_pop_req", mem_req, 1'b0);
    serve(0, 32'hB000_0010, 32'h10);
    chk("t2_refull_req", mem_req, 1'b0);
    tick();
    chk("t2_refull_req2", mem_req, 1'b0);
    inst_ready = 1'b1;
    tick();
    head("t2_h8", 32'h8, 32'hB000_0008);
    tick();
    head("t2_hc", 32'hC, 32'hB000_000C);
    tick();
    head("t2_h10", 32'h10, 32'hB000_0010);
    tick();
    chk("t2_drained", inst_valid, 1'b0);

    // 3: redirect while waiting on 0x8
    do_reset();
    serve(1, 32'hC000_0000, 32'h0);
    head("t3_0", 32'h0, 32'hC000_0000);
    serve(1, 32'hC000_0004, 32'h4);
    head("t3_4", 32'h4, 32'hC000_0004);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("t3_drop_req", mem_req, 1'b1);
    chk("t3_drop_addr", mem_addr, 32'h8);
    chk("t3_flushed", inst_valid, 1'b0);
    tick();
    chk("t3_drop_addr2", mem_addr, 32'h8);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_0008;
    tick();
    mem_ack = 1'b0;
    chk("t3_idle_req", mem_req, 1'b0);
    chk("t3_dropped", inst_valid, 1'b0);
    serve(1, 32'hC000_0100, 32'h100);
    head("t3_100", 32'h100, 32'hC000_0100);

    // 4: redirect coincident with ack
    chk("t4_addr", mem_addr, 32'h104);
    mem_ack     = 1'b1;
    mem_rdata   = 32'hDEAD_0104;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    mem_ack  = 1'b0;
    redirect = 1'b0;
    chk("t4_flushed", inst_valid, 1'b0);
    chk("t4_idle_req", mem_req, 1'b0);
    serve(0, 32'hD000_0200, 32'h200);
    head("t4_200", 32'h200, 32'hD000_0200);

    // 5: misaligned redirect to the top of memory, then PC wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    chk("t5_flushed", inst_valid, 1'b0);
    serve(0, 32'hDEAD_0204, 32'h204);
    chk("t5_dropped", inst_valid, 1'b0);
    serve(0, 32'hE000_FFFC, 32'hFFFF_FFFC);
    head("t5_top", 32'hFFFF_FFFC, 32'hE000_FFFC);
    serve(0, 32'hE000_0000, 32'h0);
    head("t5_wrap", 32'h0, 32'hE000_0000);

    // 6: asynchronous reset mid-request
    chk("t6_pre_req", mem_req, 1'b1);
    chk("t6_pre_addr", mem_addr, 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("t6_req", mem_req, 1'b0);
    chk("t6_addr", mem_addr, 32'h0);
    chk("t6_valid", inst_valid, 1'b0);
    chk("t6_out", inst_out, 32'h0);
    chk("t6_pc", inst_pc, 32'h0);
    tick();
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_FFFF;
    tick();
    mem_ack = 1'b0;
    chk("t6_stray_ack", inst_valid, 1'b0);
    serve(0, 32'hF000_0000, 32'h0);
    head("t6_0", 32'h0, 32'hF000_0000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-fetch front end that sits directly upstream of the processor core's decode logic.
- Generates sequential fetch addresses and issues them to a slow instruction memory over a req/ack handshake.
- Holds returned words in a small prefetch FIFO tagged with their PC, and presents them to the core over a valid/ready interface.
- Flushes and restarts on a branch/jump redirect from the core's next-PC logic.

Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2.
- ADDR_W, 32, fetch address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  fetch request to instruction memory; held until mem_ack.
- mem_addr  out  ADDR_W  word-aligned fetch address; stable while mem_req=1.
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid in that cycle.
- mem_rdata  in  DATA_W  returned instruction word.
- inst_valid  out  1  FIFO head is valid.
- inst_out  out  DATA_W  FIFO head instruction.
- inst_pc  out  ADDR_W  PC of inst_out.
- inst_ready  in  1  core consumes head when inst_valid & inst_ready.
- redirect  in  1  one-cycle flush request from next-PC logic.
- redirect_pc  in  ADDR_W  new fetch address; sampled when redirect=1.

Behaviour:
- Reset (async, immediate):
  - mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0.
  - FIFO count=0, rd/wr pointers=0, fetch_pc=RESET_PC, state=IDLE.
  - Reset asserted mid-transaction abandons the transaction; any ack arriving after reset release while in IDLE is ignored.
- States:
  - IDLE: mem_req=0. If redirect: fetch_pc←redirect_pc, stay IDLE. Otherwise, if count<DEPTH, go to WAIT (mem_req=1 next cycle, mem_addr=fetch_pc).
  - WAIT: mem_req=1.
    - On mem_ack without redirect: push {fetch_pc, mem_rdata}; fetch_pc←fetch_pc+4.
    - After the ack, stay in WAIT (back-to-back request at the new fetch_pc) if post-push/pop count<DEPTH, else go to IDLE.
    - On redirect without ack: go to DROP; fetch_pc←redirect_pc; FIFO flushed.
    - On redirect with ack in the same cycle: response discarded, FIFO flushed, fetch_pc←redirect_pc, go to IDLE.
  - DROP: mem_req=1 with the original address held (the handshake must complete). On mem_ack the data is discarded and the state goes to IDLE. A further redirect in DROP only updates fetch_pc.
- FIFO:
  - Single outstanding request, so the slot is guaranteed at ack time.
  - Push and pop in the same cycle are both performed; count unchanged.
  - Flush is highest priority: count=0, pointers=0, inst_valid=0 on the next cycle. A pop coinciding with the flush is ignored.
  - Pointers wrap modulo DEPTH.
- Timing and arithmetic:
  - Latency: ack at cycle N → inst_valid=1 at N+1 if the FIFO was empty. Outputs are registered from the FIFO head.
  - fetch_pc increments by 4 modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
  - redirect_pc[1:0] is forced to 0.

Optional Feature:
- Macro: FETCH_BUFFER_PERF_EN.
- Defined:
  - Adds output stall_cnt (32 bits), incremented each cycle where inst_ready=1 and inst_valid=0.
  - Adds output flush_cnt (16 bits), incremented per redirect.
  - Both counters saturate, and reset to 0.
- Undefined: neither port nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, WAIT, DROP}.
  - PC_INC=4.
  - typedef fetch_entry_t {pc, instr}.
- One sub-module: fetch_fifo (parameterised DEPTH, entry width; push/pop/flush, count, full/empty). The FSM and PC logic stay in fetch_buffer.

Test Plan:
1. Reset release, memory acks 2 cycles after each req, inst_ready=1 → PCs 0x0, 0x4, 0x8 appear in order; mem_addr never changes while mem_req=1.
2. inst_ready=0, zero-wait memory → exactly 4 entries buffered, then mem_req=0. One pop → exactly one new fetch at 0x10.
3. redirect to 0x100 while in WAIT at 0x8 → mem_req held at 0x8 until ack; that data is dropped; next request is 0x100; first inst_pc seen is 0x100.
4. redirect to 0x200 in the same cycle as mem_ack → ack data dropped; FIFO empty next cycle; next fetch is 0x200.
5. redirect_pc=0xFFFF_FFFC → inst_pc sequence 0xFFFF_FFFC, then 0x0.
6. Assert rst in the middle of WAIT → outputs reach reset values without a clock edge; the first request after release is to RESET_PC.
